// File: rtl/line_mem_if.sv
// Memory-port bundle between the cache master and the line memory slave.
// Signal names keep the slave-side i_/o_ direction view.
interface line_mem_if #(
   parameter int LINE_W = 128,
   parameter int ADDR_W = 26
);
   logic [ADDR_W-1:0]      i_addr;
   logic [LINE_W/32-1:0]   i_byte_en;
   logic [LINE_W-1:0]      i_writedata;
   logic                   i_read;
   logic                   i_write;
   logic [LINE_W-1:0]      o_readdata;
   logic                   o_readdata_valid;
   logic                   o_waitrequest;
   logic                   o_err;
   logic [31:0]            o_cnt_rd;
   logic [31:0]            o_cnt_wr;
   logic [31:0]            o_cnt_stall;

   modport slave (
      input  i_addr, i_byte_en, i_writedata, i_read, i_write,
      output o_readdata, o_readdata_valid, o_waitrequest, o_err,
      output o_cnt_rd, o_cnt_wr, o_cnt_stall
   );

   modport master (
      output i_addr, i_byte_en, i_writedata, i_read, i_write,
      input  o_readdata, o_readdata_valid, o_waitrequest, o_err,
      input  o_cnt_rd, o_cnt_wr, o_cnt_stall
   );
endinterface

// File: rtl/line_mem_slave.sv
// Line-granular memory slave: waitrequest handshake, configurable read/write latency,
// word-masked writes. Define MEM_STATS_EN to build the read/write/stall statistics counters.
module line_mem_slave #(
   parameter int LINE_W     = 128,
   parameter int ADDR_W     = 26,
   parameter int DEPTH_LOG2 = 6,
   parameter int RD_LATENCY = 2,
   parameter int WR_LATENCY = 1
) (
   input logic       clk,
   input logic       rst,
   line_mem_if.slave bus
);
   localparam int WORDS = LINE_W / 32;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD  = (WR_LATENCY > 0) ? CNT_W'(WR_LATENCY - 1) : {CNT_W{1'b0}};
   localparam bit WR_ZERO = (WR_LATENCY == 0);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [DEPTH_LOG2-1:0]   r_idx;
   logic [WORDS-1:0]        r_be;
   logic [LINE_W-1:0]       r_wdata;
   logic [LINE_W-1:0]       r_mem [DEPTH];
   logic [LINE_W-1:0]       r_rdata;
   logic                    r_rvalid;
   logic                    r_wait;
   logic                    r_err;

   logic                    w_req;
   logic                    w_accept;
   logic                    w_wr_now;
   logic                    w_wr_done;
   logic                    w_commit;
   logic [DEPTH_LOG2-1:0]   w_cidx;
   logic [WORDS-1:0]        w_cbe;
   logic [LINE_W-1:0]       w_cdata;
   logic                    w_unused_addr;

   assign w_unused_addr = ^bus.i_addr[ADDR_W-1:DEPTH_LOG2];
   assign w_req     = bus.i_read | bus.i_write;
   assign w_accept  = (r_state == IDLE) & w_req;
   assign w_wr_now  = w_accept & bus.i_write & WR_ZERO;
   assign w_wr_done = (r_state == WR_WAIT) & (r_cnt == CNT_ZERO);
   // A reset edge neither accepts a new write nor completes a pending one.
   assign w_commit  = ~rst & (w_wr_now | w_wr_done);
   assign w_cidx    = w_wr_now ? bus.i_addr[DEPTH_LOG2-1:0] : r_idx;
   assign w_cbe     = w_wr_now ? bus.i_byte_en : r_be;
   assign w_cdata   = w_wr_now ? bus.i_writedata : r_wdata;

   // Storage with per-word write enables; contents survive reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < WORDS; k++) begin
         if (w_commit && w_cbe[k]) begin
            r_mem[w_cidx][32*k +: 32] <= w_cdata[32*k +: 32];
         end
      end
   end

   // Request FSM: acceptance, latency countdown, read return and error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= CNT_ZERO;
         r_wait   <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= {LINE_W{1'b0}};
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_idx   <= bus.i_addr[DEPTH_LOG2-1:0];
                  r_be    <= bus.i_byte_en;
                  r_wdata <= bus.i_writedata;
                  r_err   <= bus.i_read & bus.i_write;
                  if (bus.i_write) begin
                     if (!WR_ZERO) begin
                        r_state <= WR_WAIT;
                        r_cnt   <= WR_LOAD;
                        r_wait  <= 1'b1;
                     end
                  end else begin
                     r_state <= RD_WAIT;
                     r_cnt   <= RD_LOAD;
                     r_wait  <= 1'b1;
                  end
               end
            end
            RD_WAIT: begin
               if (r_cnt == CNT_ZERO) begin
                  r_rdata  <= r_mem[r_idx];
                  r_rvalid <= 1'b1;
                  r_state  <= IDLE;
                  r_wait   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            WR_WAIT: begin
               if (r_cnt == CNT_ZERO) begin
                  r_state <= IDLE;
                  r_wait  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_wait  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_readdata       = r_rdata;
   assign bus.o_readdata_valid = r_rvalid;
   assign bus.o_waitrequest    = r_wait;
   assign bus.o_err            = r_err;

`ifdef MEM_STATS_EN
   logic [31:0] r_cnt_rd;
   logic [31:0] r_cnt_wr;
   logic [31:0] r_cnt_stall;

   // Statistics: a read dropped by a simultaneous write counts as a write only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt_rd    <= 32'd0;
         r_cnt_wr    <= 32'd0;
         r_cnt_stall <= 32'd0;
      end else begin
         if (w_accept && bus.i_read && !bus.i_write) begin
            r_cnt_rd <= r_cnt_rd + 32'd1;
         end
         if (w_accept && bus.i_write) begin
            r_cnt_wr <= r_cnt_wr + 32'd1;
         end
         if (w_req && r_wait) begin
            r_cnt_stall <= r_cnt_stall + 32'd1;
         end
      end
   end

   assign bus.o_cnt_rd    = r_cnt_rd;
   assign bus.o_cnt_wr    = r_cnt_wr;
   assign bus.o_cnt_stall = r_cnt_stall;
`else
   assign bus.o_cnt_rd    = 32'd0;
   assign bus.o_cnt_wr    = 32'd0;
   assign bus.o_cnt_stall = 32'd0;
`endif
endmodule

// File: tb/tb_line_mem_slave.sv
// Bench for line_mem_slave: two instances (default latencies and RD=4/WR=3) checked every
// cycle against a transaction-level memory model, plus directed literal checks.
`timescale 1ns/1ps
module tb_line_mem_slave;
   localparam int LW = 128;
   localparam int AW = 26;
   localparam int RL0 = 2, WL0 = 1, RL1 = 4, WL1 = 3;
`ifdef MEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_v [2];
   logic          rd_v  [2];
   logic          wr_v  [2];
   logic [AW-1:0] ad_v  [2];
   logic [3:0]    be_v  [2];
   logic [LW-1:0] wd_v  [2];

   logic [LW-1:0] d_rdata [2];
   logic          d_rvld  [2];
   logic          d_wait  [2];
   logic          d_err   [2];
   logic [31:0]   d_crd   [2];
   logic [31:0]   d_cwr   [2];
   logic [31:0]   d_cst   [2];

   line_mem_if #(.LINE_W(LW), .ADDR_W(AW)) b0 ();
   line_mem_if #(.LINE_W(LW), .ADDR_W(AW)) b1 ();

   assign b0.i_addr = ad_v[0]; assign b0.i_byte_en = be_v[0]; assign b0.i_writedata = wd_v[0];
   assign b0.i_read = rd_v[0]; assign b0.i_write = wr_v[0];
   assign b1.i_addr = ad_v[1]; assign b1.i_byte_en = be_v[1]; assign b1.i_writedata = wd_v[1];
   assign b1.i_read = rd_v[1]; assign b1.i_write = wr_v[1];
   assign d_rdata[0] = b0.o_readdata; assign d_rvld[0] = b0.o_readdata_valid;
   assign d_wait[0] = b0.o_waitrequest; assign d_err[0] = b0.o_err;
   assign d_crd[0] = b0.o_cnt_rd; assign d_cwr[0] = b0.o_cnt_wr; assign d_cst[0] = b0.o_cnt_stall;
   assign d_rdata[1] = b1.o_readdata; assign d_rvld[1] = b1.o_readdata_valid;
   assign d_wait[1] = b1.o_waitrequest; assign d_err[1] = b1.o_err;
   assign d_crd[1] = b1.o_cnt_rd; assign d_cwr[1] = b1.o_cnt_wr; assign d_cst[1] = b1.o_cnt_stall;

   line_mem_slave #(.LINE_W(LW), .ADDR_W(AW), .DEPTH_LOG2(6), .RD_LATENCY(RL0), .WR_LATENCY(WL0))
      dut0 (.clk(clk), .rst(rst_v[0]), .bus(b0));
   line_mem_slave #(.LINE_W(LW), .ADDR_W(AW), .DEPTH_LOG2(6), .RD_LATENCY(RL1), .WR_LATENCY(WL1))
      dut1 (.clk(clk), .rst(rst_v[1]), .bus(b1));

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // ---------------- behavioural model (transaction level) ----------------
   int unsigned   cyc = 0;
   int unsigned   m_done [2];
   bit            m_pend [2];
   bit            m_prd  [2];
   logic [5:0]    m_pidx [2];
   logic [3:0]    m_pbe  [2];
   logic [LW-1:0] m_pdat [2];
   logic [LW-1:0] mm     [2][64];
   bit            m_acc  [2];
   bit            m_vld  [2];
   bit            m_err  [2];
   logic [LW-1:0] m_rdat [2];
   logic [31:0]   m_crd  [2];
   logic [31:0]   m_cwr  [2];
   logic [31:0]   m_cst  [2];

   function automatic int rl(input int d); return (d == 0) ? RL0 : RL1; endfunction
   function automatic int wl(input int d); return (d == 0) ? WL0 : WL1; endfunction

   task automatic commit(input int d, input logic [5:0] idx, input logic [3:0] be, input logic [LW-1:0] dat);
      for (int k = 0; k < 4; k++) if (be[k]) mm[d][idx][32*k +: 32] = dat[32*k +: 32];
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         m_acc[d] = 1'b0; m_vld[d] = 1'b0; m_err[d] = 1'b0;
         if (rst_v[d]) begin
            m_pend[d] = 1'b0;
            m_crd[d] = 32'd0; m_cwr[d] = 32'd0; m_cst[d] = 32'd0;
         end else if (m_pend[d]) begin
            if (rd_v[d] || wr_v[d]) m_cst[d] = m_cst[d] + 32'd1;
            if (cyc == m_done[d]) begin
               m_pend[d] = 1'b0;
               if (m_prd[d]) begin
                  m_vld[d] = 1'b1;
                  m_rdat[d] = mm[d][m_pidx[d]];
               end else begin
                  commit(d, m_pidx[d], m_pbe[d], m_pdat[d]);
               end
            end
         end else if (rd_v[d] || wr_v[d]) begin
            m_acc[d] = 1'b1;
            m_pidx[d] = ad_v[d][5:0]; m_pbe[d] = be_v[d]; m_pdat[d] = wd_v[d];
            if (wr_v[d]) begin
               m_cwr[d] = m_cwr[d] + 32'd1;
               m_err[d] = rd_v[d];
               if (wl(d) == 0) begin
                  commit(d, m_pidx[d], m_pbe[d], m_pdat[d]);
               end else begin
                  m_pend[d] = 1'b1; m_prd[d] = 1'b0; m_done[d] = cyc + wl(d);
               end
            end else begin
               m_crd[d] = m_crd[d] + 32'd1;
               m_pend[d] = 1'b1; m_prd[d] = 1'b1; m_done[d] = cyc + rl(d);
            end
         end
      end
      cyc++;
   end

   task automatic chk(input string nm, input int d, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, d, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk("waitrequest", d, LW'(d_wait[d]), LW'(m_pend[d]));
            chk("rvalid", d, LW'(d_rvld[d]), LW'(m_vld[d]));
            chk("err", d, LW'(d_err[d]), LW'(m_err[d]));
            if (m_vld[d]) chk("rdata", d, d_rdata[d], m_rdat[d]);
            chk("cnt_rd", d, LW'(d_crd[d]), LW'(STATS ? m_crd[d] : 32'd0));
            chk("cnt_wr", d, LW'(d_cwr[d]), LW'(STATS ? m_cwr[d] : 32'd0));
            chk("cnt_stall", d, LW'(d_cst[d]), LW'(STATS ? m_cst[d] : 32'd0));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic op(input int d, input bit r, input bit w, input logic [AW-1:0] a,
                     input logic [3:0] be, input logic [LW-1:0] dat, input bit hold,
                     output int lat, output bit errs, output bit vld, output logic [LW-1:0] rdat);
      int n;
      rd_v[d] = r; wr_v[d] = w; ad_v[d] = a; be_v[d] = be; wd_v[d] = dat;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!m_acc[d] && n < 50);
      if (!m_acc[d]) begin
         checks++; failures++;
         $display("FAIL accept_timeout dut%0d actual=no_accept required=accept", d);
      end
      errs = d_err[d];
      if (!hold) begin rd_v[d] = 1'b0; wr_v[d] = 1'b0; end
      lat = 0;
      while (d_wait[d] && lat < 50) begin lat++; @(posedge clk); #1; end
      if (lat >= 50) begin
         checks++; failures++;
         $display("FAIL wait_timeout dut%0d actual=busy required=idle", d);
      end
      vld = d_rvld[d];
      rdat = d_rdata[d];
      rd_v[d] = 1'b0; wr_v[d] = 1'b0;
   endtask

   initial begin
      int lat; bit e; bit v; logic [LW-1:0] q;
      logic [LW-1:0] line3, lineA, lineB;
      line3 = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
      lineA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      lineB = 128'h11112222_33334444_55556666_77778888;
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; rd_v[d] = 1'b0; wr_v[d] = 1'b0;
         ad_v[d] = '0; be_v[d] = 4'h0; wd_v[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      chk_en = 1'b1;
      chk("reset_wait", 0, LW'(d_wait[0]), '0);
      chk("reset_rvalid", 0, LW'(d_rvld[0]), '0);
      chk("reset_rdata", 0, d_rdata[0], '0);
      chk("reset_err", 0, LW'(d_err[0]), '0);

      // RD=4/WR=3 with held requests: 3 + 4 stall cycles
      op(1, 1'b0, 1'b1, 26'd7, 4'hF, lineB, 1'b1, lat, e, v, q);
      chk("wr_wait_cycles", 1, LW'(lat), LW'(3));
      op(1, 1'b1, 1'b0, 26'd7, 4'h0, '0, 1'b1, lat, e, v, q);
      chk("rd_wait_cycles", 1, LW'(lat), LW'(4));
      chk("held_rdata", 1, q, lineB);
      chk("stat_stall", 1, LW'(d_cst[1]), LW'(STATS ? 32'd7 : 32'd0));
      chk("stat_rd", 1, LW'(d_crd[1]), LW'(STATS ? 32'd1 : 32'd0));
      chk("stat_wr", 1, LW'(d_cwr[1]), LW'(STATS ? 32'd1 : 32'd0));

      // Basic write/read and read latency
      op(0, 1'b0, 1'b1, 26'h3, 4'hF, line3, 1'b0, lat, e, v, q);
      op(0, 1'b1, 1'b0, 26'h3, 4'h0, '0, 1'b0, lat, e, v, q);
      chk("rd_latency", 0, LW'(lat), LW'(2));
      chk("rd_valid", 0, LW'(v), LW'(1));
      chk("rd_line3", 0, q, line3);

      // Word mask merge
      op(0, 1'b0, 1'b1, 26'h5, 4'hF, {LW{1'b1}}, 1'b0, lat, e, v, q);
      op(0, 1'b0, 1'b1, 26'h5, 4'b0101, '0, 1'b0, lat, e, v, q);
      op(0, 1'b1, 1'b0, 26'h5, 4'h0, '0, 1'b0, lat, e, v, q);
      chk("mask_merge", 0, q, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);

      // Index aliasing
      op(0, 1'b0, 1'b1, 26'h41, 4'hF, lineA, 1'b0, lat, e, v, q);
      op(0, 1'b1, 1'b0, 26'h01, 4'h0, '0, 1'b0, lat, e, v, q);
      chk("alias", 0, q, lineA);

      // Simultaneous read+write: write wins, error pulse, no read return
      op(0, 1'b1, 1'b1, 26'h2, 4'hF, lineB, 1'b0, lat, e, v, q);
      chk("err_pulse", 0, LW'(e), LW'(1));
      chk("err_no_valid", 0, LW'(v), LW'(0));
      op(0, 1'b1, 1'b0, 26'h2, 4'h0, '0, 1'b0, lat, e, v, q);
      chk("err_write_committed", 0, q, lineB);

      // Reset one cycle into RD_WAIT
      rd_v[0] = 1'b1; ad_v[0] = 26'h3;
      @(posedge clk); #1;
      rd_v[0] = 1'b0; rst_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_v[0] = 1'b0;
      chk("rst_rd_wait", 0, LW'(d_wait[0]), '0);
      chk("rst_rd_valid", 0, LW'(d_rvld[0]), '0);
      chk("rst_cnt_rd", 0, LW'(d_crd[0]), '0);
      chk("rst_cnt_wr", 0, LW'(d_cwr[0]), '0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("rst_no_late_valid", 0, LW'(d_rvld[0]), '0);
      end

      // Fill every line so random reads are defined
      fork
         begin
            int l0; bit e0; bit v0; logic [LW-1:0] q0;
            for (int i = 0; i < 64; i++)
               op(0, 1'b0, 1'b1, AW'(i), 4'hF, {$urandom, $urandom, $urandom, $urandom}, 1'b0, l0, e0, v0, q0);
         end
         begin
            int l1; bit e1; bit v1; logic [LW-1:0] q1;
            for (int i = 0; i < 64; i++)
               op(1, 1'b0, 1'b1, AW'(i), 4'hF, {$urandom, $urandom, $urandom, $urandom}, 1'b0, l1, e1, v1, q1);
         end
      join

      // Random traffic, including occasional resets, checked against the model
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            rd_v[d]  = ($urandom_range(0, 2) == 0);
            wr_v[d]  = ($urandom_range(0, 2) == 0);
            ad_v[d]  = AW'($urandom);
            be_v[d]  = 4'($urandom);
            wd_v[d]  = {$urandom, $urandom, $urandom, $urandom};
            rst_v[d] = ($urandom_range(0, 149) == 0);
         end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin rd_v[d] = 1'b0; wr_v[d] = 1'b0; rst_v[d] = 1'b0; end
      repeat (8) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
